// File: rtl/k_dp_sync_fifo.sv
// Single-clock FIFO over a dual-port register array with registered read data,
// registered status flags, occupancy count and overflow/underflow pulses.
module k_dp_sync_fifo #(
  parameter int data_size = 8,
  parameter int addr_size = 4,
  parameter int af_level  = 12,
  parameter int ae_level  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [data_size-1:0] d,
  input  logic                 wen,
  input  logic                 ren,
  output logic [data_size-1:0] q,
  output logic                 q_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [addr_size:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int depth = 1 << addr_size;
  localparam logic [addr_size:0] depth_lvl = {1'b1, {addr_size{1'b0}}};
  localparam logic [addr_size:0] af_lvl    = af_level[addr_size:0];
  localparam logic [addr_size:0] ae_lvl    = ae_level[addr_size:0];

  logic [data_size-1:0] mem [0:depth-1];

  logic [addr_size-1:0] wptr_reg, rptr_reg;
  logic [addr_size:0]   count_reg, count_next;
  logic [data_size-1:0] q_reg;
  logic                 q_valid_reg;
  logic                 full_reg, empty_reg, almost_full_reg, almost_empty_reg;
  logic                 overflow_reg, underflow_reg;
  logic                 wr_ok, rd_ok;

  // Acceptance uses the registered flags, so a full FIFO never takes a write
  // even when a read frees a slot in the same cycle.
  assign wr_ok = wen & ~full_reg;
  assign rd_ok = ren & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    if (wr_ok && !rd_ok)
      count_next = count_reg + 1'b1;
    else if (rd_ok && !wr_ok)
      count_next = count_reg - 1'b1;
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wptr_reg] <= d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg         <= '0;
      rptr_reg         <= '0;
      count_reg        <= '0;
      q_reg            <= '0;
      q_valid_reg      <= 1'b0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      if (wr_ok)
        wptr_reg <= wptr_reg + 1'b1;
      if (rd_ok) begin
        rptr_reg <= rptr_reg + 1'b1;
        q_reg    <= mem[rptr_reg];
      end
      q_valid_reg      <= rd_ok;
      count_reg        <= count_next;
      full_reg         <= (count_next == depth_lvl);
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= af_lvl);
      almost_empty_reg <= (count_next <= ae_lvl);
      overflow_reg     <= wen & full_reg;
      underflow_reg    <= ren & empty_reg;
    end
  end

  assign q            = q_reg;
  assign q_valid      = q_valid_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_k_dp_sync_fifo.sv
// Directed bench for k_dp_sync_fifo: a vector table for reset/fill/drain plus
// hand-written sequences for overflow, underflow, streaming wrap and mid-run reset.
module tb_k_dp_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d   = '0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic [7:0] q;
  logic       q_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int checks   = 0;
  int failures = 0;

  k_dp_sync_fifo #(.data_size(8), .addr_size(4), .af_level(12), .ae_level(2)) dut (
    .clk(clk), .rst(rst), .d(d), .wen(wen), .ren(ren),
    .q(q), .q_valid(q_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, wen, ren;
    logic [7:0] d;
    int         cnt;
    logic       full, empty, af, ae, qv;
    logic [7:0] q;
    logic       ovf, udf;
  } vec_t;

  vec_t vt [35];

  function automatic vec_t mk(logic r, logic w, logic rd, logic [7:0] dd, int c,
                              logic qv, logic [7:0] qq);
    vec_t v;
    v.rst = r; v.wen = w; v.ren = rd; v.d = dd; v.cnt = c;
    v.full = (c == 16); v.empty = (c == 0); v.af = (c >= 12); v.ae = (c <= 2);
    v.qv = qv; v.q = qq; v.ovf = 1'b0; v.udf = 1'b0;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(logic r, logic w, logic rd, logic [7:0] dd);
    rst = r; wen = w; ren = rd; d = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(string tag, int c, logic qv, logic [7:0] qe,
                              logic ovf, logic udf);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".q_valid"}, int'(q_valid), int'(qv));
    chk({tag, ".q"}, int'(q), int'(qe));
    chk({tag, ".overflow"}, int'(overflow), int'(ovf));
    chk({tag, ".underflow"}, int'(underflow), int'(udf));
    $display("txn %-6s wen=%0b ren=%0b d=%02h -> count=%0d q=%02h qv=%0b ovf=%0b udf=%0b",
             tag, wen, ren, d, count, q, q_valid, overflow, underflow);
  endtask

  initial begin
    // Table: reset, idle, 16 writes, 16 reads, idle.
    vt[0] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00);
    vt[1] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++)
      vt[2 + i] = mk(0, 1, 0, 8'(i + 1), i + 1, 0, 8'h00);
    for (int j = 0; j < 16; j++)
      vt[18 + j] = mk(0, 0, 1, 8'h00, 15 - j, 1, 8'(j + 1));
    vt[34] = mk(0, 0, 0, 8'h00, 0, 0, 8'h10);

    for (int n = 0; n < 35; n++) begin
      string tag;
      tag = $sformatf("v%0d", n);
      step(vt[n].rst, vt[n].wen, vt[n].ren, vt[n].d);
      chk({tag, ".full"}, int'(full), int'(vt[n].full));
      chk({tag, ".empty"}, int'(empty), int'(vt[n].empty));
      chk({tag, ".almost_full"}, int'(almost_full), int'(vt[n].af));
      chk({tag, ".almost_empty"}, int'(almost_empty), int'(vt[n].ae));
      expect_state(tag, vt[n].cnt, vt[n].qv, vt[n].q, vt[n].ovf, vt[n].udf);
    end

    // Overflow: full FIFO with wen+ren reads oldest, drops the write.
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'h20 + i));
    chk("ovf.pre_full", int'(full), 1);
    step(0, 1, 1, 8'hEE);
    chk("ovf.full_after", int'(full), 0);
    expect_state("ovf", 15, 1, 8'h20, 1, 0);
    step(0, 0, 0, 8'h00);
    expect_state("ovf_i", 15, 0, 8'h20, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 1, 8'h00);
      expect_state("ovf_rd", 14 - i, 1, 8'(8'h21 + i), 0, 0);
    end
    chk("ovf.empty_end", int'(empty), 1);

    // Underflow: empty FIFO with wen+ren writes only, no fall-through.
    step(0, 1, 1, 8'hA5);
    chk("udf.empty", int'(empty), 0);
    expect_state("udf", 1, 0, 8'h2F, 0, 1);
    step(0, 0, 1, 8'h00);
    expect_state("udf_rd", 0, 1, 8'hA5, 0, 0);

    // Streaming at occupancy 8 across several pointer wraps.
    for (int k = 0; k < 8; k++) step(0, 1, 0, 8'(k));
    chk("strm.count", int'(count), 8);
    for (int k = 0; k < 40; k++) begin
      step(0, 1, 1, 8'(8 + k));
      expect_state("strm", 8, 1, 8'(k), 0, 0);
    end
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 8'h00);
      expect_state("drain", 7 - k, 1, 8'(40 + k), 0, 0);
    end

    // Reset mid-run beats a concurrent write and discards stored words.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h50 + i));
    chk("rst.pre_count", int'(count), 5);
    step(1, 1, 0, 8'h77);
    chk("rst.empty", int'(empty), 1);
    chk("rst.almost_empty", int'(almost_empty), 1);
    expect_state("rst", 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 8'h3C);
    expect_state("rst_wr", 1, 0, 8'h00, 0, 0);
    step(0, 0, 1, 8'h00);
    expect_state("rst_rd", 0, 1, 8'h3C, 0, 0);
    step(0, 0, 1, 8'h00);
    expect_state("rst_ud", 0, 0, 8'h3C, 0, 1);
    step(0, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
